// File: rtl/pkt_rd_engine_if.sv
// rtl/pkt_rd_engine_if.sv - Avalon-MM read port and framed output stream of pkt_rd_engine
interface pkt_rd_engine_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              mem_read;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_waitrequest;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_readdatavalid;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_sop;
  logic              out_eop;
  logic              out_ready;

  modport master (
    output mem_read, mem_address,
    input  mem_waitrequest, mem_readdata, mem_readdatavalid,
    output out_valid, out_data, out_sop, out_eop,
    input  out_ready
  );

  modport slave (
    input  mem_read, mem_address,
    output mem_waitrequest, mem_readdata, mem_readdatavalid,
    input  out_valid, out_data, out_sop, out_eop,
    output out_ready
  );
endinterface

// File: rtl/pkt_rd_engine.sv
// rtl/pkt_rd_engine.sv - packet read responder: one-at-a-time memory reads forwarded as an SOP/EOP stream
module pkt_rd_engine #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [LEN_W-1:0]  i_len_words,
  pkt_rd_engine_if.master   bus,
  output logic              o_rdy,
  output logic              o_busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_first;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_sop;
  logic              r_out_eop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_first     <= 1'b0;
      r_out_data  <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_addr      <= i_base_addr;
            r_remaining <= i_len_words;
            r_first     <= 1'b1;
            r_state     <= (i_len_words == '0) ? S_DONE : S_REQ;
          end
        end
        S_REQ: begin
          if (!bus.mem_waitrequest) r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Frame flags are fixed at capture so they stay stable under backpressure.
          if (bus.mem_readdatavalid) begin
            r_out_data <= bus.mem_readdata;
            r_out_sop  <= r_first;
            r_out_eop  <= (r_remaining == LEN_W'(1));
            r_state    <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_addr      <= r_addr + ADDR_W'(1);
            r_remaining <= r_remaining - LEN_W'(1);
            r_first     <= 1'b0;
            r_state     <= r_out_eop ? S_DONE : S_REQ;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_read    = (r_state == S_REQ);
  assign bus.mem_address = r_addr;
  assign bus.out_valid   = (r_state == S_OUT);
  assign bus.out_data    = r_out_data;
  assign bus.out_sop     = r_out_sop;
  assign bus.out_eop     = r_out_eop;
  assign o_rdy           = (r_state == S_DONE);
  assign o_busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_pkt_rd_engine.sv
// tb/tb_pkt_rd_engine.sv - directed bench for pkt_rd_engine with a packet-level reference model
module tb_pkt_rd_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic [10:0] len_words;
  logic        rdy;
  logic        busy;

  pkt_rd_engine_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  pkt_rd_engine #(.ADDR_W(16), .DATA_W(32), .LEN_W(11)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (start),
    .i_base_addr (base_addr),
    .i_len_words (len_words),
    .bus         (bus),
    .o_rdy       (rdy),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } word_t;

  int n_pass  = 0;
  int n_total = 0;

  word_t       exp_q[$];
  logic [15:0] exp_addr_q[$];
  logic        m_busy      = 1'b0;
  logic        rdy_next    = 1'b0;
  logic        outstanding = 1'b0;
  logic        prev_valid  = 1'b0;
  logic        prev_ready  = 1'b0;
  logic [31:0] prev_data   = '0;

  int          word_cnt, rdy_cnt, held_cnt, mem_read_cycles;
  logic [31:0] first_data, last_data;
  logic        last_sop, last_eop;

  int          stall_cycles = 0;
  int          ready_mode   = 0;
  logic        tog          = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic clear_stats();
    word_cnt = 0; rdy_cnt = 0; held_cnt = 0; mem_read_cycles = 0;
    first_data = '1; last_data = '1; last_sop = 1'b0; last_eop = 1'b0;
    tog = 1'b0;
  endtask

  task automatic cmd(input logic [15:0] a, input logic [10:0] n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = a; len_words = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy) begin
      n_total++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles", budget);
    end
  endtask

  // Memory slave (word = address, read latency 1, optional stall) and stream sink.
  initial begin
    logic        pend;
    logic [15:0] pend_addr;
    int          stall_cnt;
    pend = 1'b0; pend_addr = '0; stall_cnt = 0;
    bus.mem_waitrequest   = 1'b0;
    bus.mem_readdata      = '0;
    bus.mem_readdatavalid = 1'b0;
    bus.out_ready         = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.mem_readdatavalid = 1'b0;
      if (pend) begin
        bus.mem_readdatavalid = 1'b1;
        bus.mem_readdata      = {16'h0000, pend_addr};
        pend = 1'b0;
      end
      if (bus.mem_read) begin
        if (stall_cnt < stall_cycles) begin
          bus.mem_waitrequest = 1'b1;
          stall_cnt++;
        end else begin
          bus.mem_waitrequest = 1'b0;
          stall_cnt = 0;
          pend      = 1'b1;
          pend_addr = bus.mem_address;
        end
      end else begin
        bus.mem_waitrequest = 1'b0;
      end
      if (ready_mode == 0) bus.out_ready = 1'b1;
      else if (ready_mode == 2) bus.out_ready = 1'b0;
      else if (bus.out_valid) begin
        bus.out_ready = tog;
        tog = ~tog;
      end else bus.out_ready = 1'b0;
    end
  end

  // Reference model and per-cycle comparison.
  always @(negedge clk) begin
    logic  was_busy;
    word_t e;
    if (!reset) begin
      exp_q.delete();
      exp_addr_q.delete();
      m_busy = 1'b0; rdy_next = 1'b0; outstanding = 1'b0;
      prev_valid = 1'b0; prev_ready = 1'b0;
    end else begin
      was_busy = m_busy;
      check("busy", busy, m_busy);
      check("rdy", rdy, rdy_next);
      if (rdy_next) begin
        m_busy = 1'b0;
        rdy_cnt++;
      end
      rdy_next = 1'b0;

      if (start && !was_busy) begin
        m_busy = 1'b1;
        for (int i = 0; i < int'(len_words); i++) begin
          logic [15:0] a;
          a = base_addr + 16'(i);
          exp_addr_q.push_back(a);
          e.data = {16'h0000, a};
          e.sop  = (i == 0);
          e.eop  = (i == int'(len_words) - 1);
          exp_q.push_back(e);
        end
        if (len_words == 0) rdy_next = 1'b1;
      end

      if (bus.mem_read) begin
        mem_read_cycles++;
        check("single_outstanding", outstanding, 1'b0);
        if (exp_addr_q.size() == 0) check("mem_read_unexpected", bus.mem_read, 1'b0);
        else begin
          check("mem_address", bus.mem_address, exp_addr_q[0]);
          if (!bus.mem_waitrequest) begin
            void'(exp_addr_q.pop_front());
            outstanding = 1'b1;
          end
        end
      end
      if (bus.mem_readdatavalid) outstanding = 1'b0;

      if (prev_valid && !prev_ready) begin
        held_cnt++;
        check("valid_held", bus.out_valid, 1'b1);
        check("data_held", bus.out_data, prev_data);
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) check("out_valid_unexpected", bus.out_valid, 1'b0);
        else begin
          e = exp_q[0];
          check("out_data", bus.out_data, e.data);
          check("out_sop", bus.out_sop, e.sop);
          check("out_eop", bus.out_eop, e.eop);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            if (word_cnt == 0) first_data = bus.out_data;
            word_cnt++;
            last_data = bus.out_data;
            last_sop  = bus.out_sop;
            last_eop  = bus.out_eop;
            if (e.eop) rdy_next = 1'b1;
          end
        end
      end
      prev_valid = bus.out_valid;
      prev_ready = bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    reset = 1'b0; start = 1'b0; base_addr = '0; len_words = '0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_read", bus.mem_read, 1'b0);
    check("rst_mem_address", bus.mem_address, 16'h0000);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 32'h0);
    check("rst_out_sop", bus.out_sop, 1'b0);
    check("rst_out_eop", bus.out_eop, 1'b0);
    check("rst_rdy", rdy, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b1;

    // Basic read
    clear_stats();
    cmd(16'h0100, 11'd4);
    check("t1_mem_read_n1", bus.mem_read, 1'b1);
    check("t1_addr_n1", bus.mem_address, 16'h0100);
    @(posedge clk); #1;
    check("t1_valid_n2", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    check("t1_valid_n3", bus.out_valid, 1'b1);
    check("t1_data_n3", bus.out_data, 32'h100);
    check("t1_sop_n3", bus.out_sop, 1'b1);
    wait_idle(200);
    check("t1_words", word_cnt, 4);
    check("t1_rdy_cnt", rdy_cnt, 1);
    check("t1_first", first_data, 32'h100);
    check("t1_last", last_data, 32'h103);
    check("t1_last_eop", last_eop, 1'b1);
    check("t1_read_cycles", mem_read_cycles, 4);

    // Stalls and backpressure
    stall_cycles = 3; ready_mode = 1;
    clear_stats();
    cmd(16'h0500, 11'd4);
    wait_idle(400);
    check("t2_words", word_cnt, 4);
    check("t2_rdy_cnt", rdy_cnt, 1);
    check("t2_held", held_cnt, 4);
    check("t2_read_cycles", mem_read_cycles, 16);
    check("t2_last", last_data, 32'h503);
    stall_cycles = 0; ready_mode = 0;

    // Zero length
    clear_stats();
    cmd(16'h0300, 11'd0);
    check("t3_rdy_n1", rdy, 1'b1);
    check("t3_mem_read_n1", bus.mem_read, 1'b0);
    @(posedge clk); #1;
    check("t3_rdy_n2", rdy, 1'b0);
    check("t3_busy_n2", busy, 1'b0);
    check("t3_read_cycles", mem_read_cycles, 0);
    check("t3_words", word_cnt, 0);
    check("t3_rdy_cnt", rdy_cnt, 1);

    // Single word
    clear_stats();
    cmd(16'h0077, 11'd1);
    wait_idle(100);
    check("t4_words", word_cnt, 1);
    check("t4_data", last_data, 32'h77);
    check("t4_sop", last_sop, 1'b1);
    check("t4_eop", last_eop, 1'b1);
    check("t4_rdy_cnt", rdy_cnt, 1);

    // Address wrap with an ignored second start
    clear_stats();
    cmd(16'hFFFE, 11'd3);
    repeat (2) @(posedge clk);
    cmd(16'h1234, 11'd5);
    wait_idle(200);
    repeat (5) @(posedge clk);
    #1;
    check("t5_words", word_cnt, 3);
    check("t5_first", first_data, 32'hFFFE);
    check("t5_last", last_data, 32'h0000);
    check("t5_rdy_cnt", rdy_cnt, 1);
    check("t5_busy", busy, 1'b0);

    // Reset mid-packet while stalled on out_ready
    ready_mode = 2;
    clear_stats();
    cmd(16'h0300, 11'd3);
    k = 0;
    while (!bus.out_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("t6_reached_out", bus.out_valid, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("t6_valid_after_rst", bus.out_valid, 1'b0);
    check("t6_busy_after_rst", busy, 1'b0);
    check("t6_rdy_after_rst", rdy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_rdy", rdy_cnt, 0);
    ready_mode = 0;
    clear_stats();
    cmd(16'h0040, 11'd2);
    wait_idle(100);
    check("t6_words", word_cnt, 2);
    check("t6_last", last_data, 32'h41);
    check("t6_rdy_cnt", rdy_cnt, 1);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pkt_rd_engine.md
# pkt_rd_engine

Read-side responder for the packet controller's read command. On a one-cycle `start` pulse it fetches a packet of `len_words` words from packet memory over an Avalon-MM read master port, one outstanding read at a time. It forwards each word onto a streaming output with SOP/EOP framing and valid/ready backpressure. It returns a one-cycle `rdy` pulse to the controller when the last word has been accepted downstream.

## Interface
- `ADDR_W`, default 16: memory word-address width
- `DATA_W`, default 32: memory and stream data width
- `LEN_W`, default 11: packet length field width, in words
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-low
- `start`  in  1  one-cycle read command from the packet controller
- `base_addr`  in  ADDR_W  first word address, sampled with `start`
- `len_words`  in  LEN_W  packet length in words, sampled with `start`
- `mem_read`  out  1  Avalon read request
- `mem_address`  out  ADDR_W  Avalon word address
- `mem_waitrequest`  in  1  Avalon stall
- `mem_readdata`  in  DATA_W  Avalon read data
- `mem_readdatavalid`  in  1  Avalon read data valid
- `out_valid`  out  1  stream word valid
- `out_data`  out  DATA_W  stream word
- `out_sop`  out  1  first word of packet, qualified by `out_valid`
- `out_eop`  out  1  last word of packet, qualified by `out_valid`
- `out_ready`  in  1  stream sink accepts the word
- `rdy`  out  1  one-cycle completion pulse to the controller
- `busy`  out  1  high in every state except IDLE

## Operation
- States: IDLE, REQ, WAIT, OUT, DONE. All outputs are registered or decoded from the registered state.
- IDLE:
  - On `start`, latch `base_addr` into `addr`, latch `len_words` into `remaining`, and set `first`=1.
  - If `len_words`==0, go to DONE. Otherwise go to REQ.
  - `start` in any state other than IDLE is ignored.
- REQ:
  - `mem_read`=1 and `mem_address`=`addr`.
  - Hold while `mem_waitrequest`=1.
  - When `mem_waitrequest`=0, go to WAIT.
- WAIT:
  - `mem_read`=0.
  - On `mem_readdatavalid`, capture `mem_readdata` into `out_data`. Set `out_sop`=`first` and `out_eop`=(`remaining`==1). Go to OUT.
  - `mem_readdatavalid` in any state other than WAIT is ignored.
- OUT:
  - `out_valid`=1. `out_data`, `out_sop` and `out_eop` stay stable until accepted.
  - On `out_ready`: `addr`+1 (wraps modulo 2^ADDR_W), `remaining`−1, `first`=0.
  - After the accept, go to DONE if this word carried EOP. Otherwise go to REQ.
- DONE: `rdy`=1 for exactly one cycle, then go to IDLE.
- Reset at any point: state goes to IDLE and the current packet is abandoned. No `rdy` is issued and no partial EOP is emitted.
- Reset values: `mem_read`=0, `mem_address`=0, `out_valid`=0, `out_data`=0, `out_sop`=0, `out_eop`=0, `rdy`=0, `busy`=0.

## Timing
- `start` sampled at edge N → REQ from edge N+1, so `mem_read` is high in cycle N+1.
- With `mem_waitrequest`=0 and read latency L (`mem_readdatavalid` L cycles after the accepted request), `out_valid` rises L+1 cycles after the accepted request.
- With zero stall and `out_ready` held at 1, per-word period is L+2 cycles.
- `rdy` is asserted in the cycle after the EOP word is accepted.
- `len_words`=0: `rdy` in cycle N+1; no memory or stream activity.
- A single-word packet carries `out_sop`=`out_eop`=1 on the same word.
- Only one read is outstanding at any time.
- `out_valid` never drops without an accept (`out_ready`=1).

## Test plan
- Basic read: `base_addr`=0x0100, `len_words`=4, memory holds word = address, no stalls, `out_ready`=1.
  - Reads at 0x0100..0x0103.
  - Stream 0x100..0x103, SOP on the first word, EOP on the fourth.
  - One `rdy` pulse; `busy` falls with IDLE.
- Stalls and backpressure: `mem_waitrequest` high for 3 cycles per request; `out_ready` toggling 1/0.
  - `mem_address` stable while stalled.
  - `out_data` stable while `out_ready`=0.
  - Exactly 4 words delivered, in order.
- Edge lengths:
  - `len_words`=0 → `rdy` one cycle after `start`, `mem_read` never asserted.
  - `len_words`=1 → one word with SOP=EOP=1.
- Wrap and ignored start: `base_addr`=0xFFFE, `len_words`=3.
  - Addresses 0xFFFE, 0xFFFF, 0x0000.
  - A second `start` pulsed mid-packet has no effect; only one `rdy`.
- Reset mid-packet: `reset`=0 while in OUT with `out_ready`=0.
  - Next cycle: `out_valid`=0, `busy`=0, no `rdy`.
  - A following `start` with `len_words`=2 completes normally.
